i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter pDEV_ADDR, default 7'h42: 7-bit device address this target responds to.
REQ-002 SHALL have parameter pFILTER, default 3: number of consecutive equal synchronized samples needed to accept a new SCL/SDA level.
REQ-003 SHALL have port iCLK, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port iRESET_N, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port iSCL, input, 1 bit: bus SCL from the master, asynchronous; the target never stretches the clock.
REQ-006 SHALL have port bSDA, inout, 1 bit: open-drain SDA; the target drives only 1'b0 or Hi-Z.
REQ-007 SHALL have port oREG_ADDR, output, 8 bits: current register pointer.
REQ-008 SHALL have port oREG_WDATA, output, 8 bits: received write byte.
REQ-009 SHALL have port oREG_WE, output, 1 bit: one-cycle write strobe.
REQ-010 SHALL have port iREG_RDATA, input, 8 bits: register contents at oREG_ADDR, valid combinationally.
REQ-011 SHALL have port oBUSY, output, 1 bit: high from an address-matched START until STOP or address mismatch.

Function
REQ-012 SHALL pass iSCL and bSDA each through a 2-flop synchronizer, then a pFILTER-sample glitch filter; all edge and condition detection uses the filtered levels.
REQ-013 SHALL detect START as a filtered SDA fall while filtered SCL is high, and STOP as a filtered SDA rise while filtered SCL is high.
REQ-014 SHALL sample SDA on the filtered SCL rise, and change its SDA drive only on the cycle after a filtered SCL fall.
REQ-015 SHALL use FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-016 SHALL enter ADDR on any START, including a repeated START, from every state, aborting any byte in progress.
REQ-017 SHALL enter IDLE on any STOP from every state and release SDA.
REQ-018 In ADDR, after 8 bits: on address match go to ADDR_ACK; on mismatch go to WAIT_STOP with SDA released.
REQ-019 In ADDR_ACK, SHALL drive SDA low for the 9th clock; then go to RDATA if R/W=1, otherwise go to PTR.
REQ-020 In PTR, the first write byte SHALL load oREG_ADDR; the target then ACKs it in PTR_ACK and goes to WDATA.
REQ-021 In WDATA, each byte SHALL set oREG_WDATA and pulse oREG_WE for exactly 1 cycle at the 8th-bit SCL rise, with oREG_ADDR unchanged during the pulse.
REQ-022 After each WDATA byte, oREG_ADDR SHALL increment at the next cycle; the target then ACKs in WDATA_ACK and returns to WDATA.
REQ-023 In RDATA, SHALL latch iREG_RDATA into the shift register on the SCL fall that ends the preceding ACK, then shift it out MSB first, driving SDA low for each 0 bit and releasing SDA for each 1 bit.
REQ-024 In RDATA_ACK, SHALL release SDA and sample the master's ACK; on ACK (0), increment oREG_ADDR and go to RDATA; on NACK (1), go to WAIT_STOP.
REQ-025 oREG_ADDR SHALL wrap from 8'hFF to 8'h00 and SHALL persist across transactions.
REQ-026 SHALL never drive SDA low while filtered SCL is high, except when holding an ACK or data bit driven from the preceding low phase.
REQ-027 A START or STOP occurring mid-byte SHALL discard partial bits and SHALL NOT pulse oREG_WE.

Reset
REQ-028 On iRESET_N low, SHALL immediately release SDA (asynchronous), enter IDLE, and clear oREG_ADDR, oREG_WDATA, oREG_WE, oBUSY, the shift register, and the bit counter to 0.
REQ-029 On iRESET_N low, SHALL set synchronizer and filter state to 1 (bus idle).
REQ-030 Reset asserted mid-transfer SHALL leave the bus released; after reset the target SHALL ignore the bus until the next START.

Structure
REQ-031 State enum and the ACK/NACK and R/W bit constants SHALL live in shared package i2c_pkg.
REQ-032 Synchronizer plus glitch filter SHALL be one sub-module, i2c_in_filter, instantiated twice (SCL, SDA).
REQ-033 Target size SHALL be 150-300 RTL lines.

Verification
REQ-034 Write 0x84 (addr 0x42, W), ptr 0x10, data 0xA5, 0x5A, STOP -> 3 ACKs; WE pulses with (0x10,0xA5), (0x11,0x5A); oREG_ADDR=0x12.
REQ-035 Read 0x85, RDATA model = addr^0xFF, pointer 0x12, master ACK, ACK, NACK -> bytes 0xED, 0xEC, 0xEB on SDA; WAIT_STOP; STOP -> IDLE.
REQ-036 Address 0x86 -> no ACK (SDA high on 9th clock); no WE for following bytes; oBUSY stays 0.
REQ-037 Pointer 0xFF, write two bytes -> WE at 0xFF then 0x00.
REQ-038 Write ptr 0x20, repeated START, read -> data from 0x20 with no WE.
REQ-039 START, then STOP after 4 data bits -> no WE.
REQ-040 Reset pulse during a read byte -> SDA released within 1 cycle and state = IDLE.
REQ-041 1-cycle SDA glitch while SCL high -> no false START/STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C target: FSM state encoding, bus bit
// constants and the byte length used by the bit counter.
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } i2c_state_e;

  localparam logic cACK      = 1'b0;
  localparam logic cNACK     = 1'b1;
  localparam logic cRW_READ  = 1'b1;
  localparam logic cRW_WRITE = 1'b0;

  localparam logic [3:0] cBITS_PER_BYTE = 4'd8;

endpackage

// File: rtl/i2c_in_filter.sv
// -----------------------------------------------------------------------------
// i2c_in_filter
// Brings one asynchronous bus line into the iCLK domain through a 2-flop
// synchronizer, then accepts a new level only after pFILTER consecutive equal
// synchronized samples. Everything resets to 1 (idle bus level).
//   iCLK     : system clock
//   iRESET_N : asynchronous active-low reset
//   iASYNC   : raw bus line
//   oLEVEL   : filtered level
// -----------------------------------------------------------------------------
module i2c_in_filter #(
  parameter int pFILTER = 3
) (
  input  logic iCLK,
  input  logic iRESET_N,
  input  logic iASYNC,
  output logic oLEVEL
);

  localparam int cCNT_W = (pFILTER > 1) ? $clog2(pFILTER) : 1;

  logic [1:0]        r_sync;
  logic              r_level;
  logic [cCNT_W-1:0] r_cnt;

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], iASYNC};
      // r_cnt counts how many samples in a row have disagreed with the
      // accepted level; any agreeing sample restarts the count.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == cCNT_W'(pFILTER - 1)) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign oLEVEL = r_level;

endmodule

// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target
// I2C target with an 8-bit register pointer. A write sets the pointer with
// its first byte and then writes each further byte at the pointer, which
// auto-increments. A read returns bytes from the pointer, incrementing after
// every master ACK. The target never stretches SCL.
//   iCLK        : system clock (rising edge)
//   iRESET_N    : asynchronous active-low reset
//   iSCL        : bus SCL (asynchronous)
//   bSDA        : open-drain SDA, driven only as 0 or Hi-Z
//   oREG_ADDR   : register pointer
//   oREG_WDATA  : last received write byte
//   oREG_WE     : one-cycle write strobe
//   iREG_RDATA  : register contents at oREG_ADDR
//   oBUSY       : addressed and not yet released by STOP or mismatch
//   oSTATE      : FSM state, for debug
// -----------------------------------------------------------------------------
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] pDEV_ADDR = 7'h42,
  parameter int          pFILTER  = 3
) (
  input  logic       iCLK,
  input  logic       iRESET_N,
  input  logic       iSCL,
  inout  wire        bSDA,
  output logic [7:0] oREG_ADDR,
  output logic [7:0] oREG_WDATA,
  output logic       oREG_WE,
  input  logic [7:0] iREG_RDATA,
  output logic       oBUSY,
  output logic [3:0] oSTATE
);

  logic       w_scl;
  logic       w_sda;
  logic       r_scl_d;
  logic       r_sda_d;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;
  logic       w_addr_match;

  i2c_state_e r_state;
  i2c_state_e w_next;

  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_we;
  logic       r_busy;
  logic [7:0] r_shift;
  logic [3:0] r_bit_cnt;
  logic       r_sda_oe;
  logic       r_rw;

  i2c_in_filter #(.pFILTER(pFILTER)) u_scl_filter (
    .iCLK     (iCLK),
    .iRESET_N (iRESET_N),
    .iASYNC   (iSCL),
    .oLEVEL   (w_scl)
  );

  i2c_in_filter #(.pFILTER(pFILTER)) u_sda_filter (
    .iCLK     (iCLK),
    .iRESET_N (iRESET_N),
    .iASYNC   (bSDA),
    .oLEVEL   (w_sda)
  );

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl_rise   = w_scl & ~r_scl_d;
  assign w_scl_fall   = ~w_scl & r_scl_d;
  // Bus conditions require SCL high both before and after the SDA edge.
  assign w_start      = r_sda_d & ~w_sda & w_scl & r_scl_d;
  assign w_stop       = ~r_sda_d & w_sda & w_scl & r_scl_d;
  assign w_byte       = {r_shift[6:0], w_sda};
  assign w_addr_match = (r_shift[7:1] == pDEV_ADDR);

  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) r_state <= ST_IDLE;
    else           r_state <= w_next;
  end

  // Byte states move to their ACK state on the SCL fall after the 8th bit,
  // so the ACK drive starts in the low phase; ACK states leave on the fall
  // that ends the 9th clock. A master NACK is final as soon as it is sampled.
  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = ST_ADDR;
    end else if (w_stop) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_ADDR:
          if (w_scl_fall && r_bit_cnt == cBITS_PER_BYTE)
            w_next = w_addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK:
          if (w_scl_fall) w_next = (r_rw == cRW_READ) ? ST_RDATA : ST_PTR;
        ST_PTR:
          if (w_scl_fall && r_bit_cnt == cBITS_PER_BYTE) w_next = ST_PTR_ACK;
        ST_PTR_ACK:
          if (w_scl_fall) w_next = ST_WDATA;
        ST_WDATA:
          if (w_scl_fall && r_bit_cnt == cBITS_PER_BYTE) w_next = ST_WDATA_ACK;
        ST_WDATA_ACK:
          if (w_scl_fall) w_next = ST_WDATA;
        ST_RDATA:
          if (w_scl_fall && r_bit_cnt == cBITS_PER_BYTE) w_next = ST_RDATA_ACK;
        ST_RDATA_ACK:
          if (w_scl_rise && w_sda == cNACK) w_next = ST_WAIT_STOP;
          else if (w_scl_fall)               w_next = ST_RDATA;
        default: w_next = r_state;
      endcase
    end
  end

  // Datapath. SDA drive is registered off the edge-detect cycle, so it only
  // ever changes the cycle after a filtered SCL fall (or on START/STOP/reset,
  // where it is released).
  always_ff @(posedge iCLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      r_addr    <= 8'h00;
      r_wdata   <= 8'h00;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_shift   <= 8'h00;
      r_bit_cnt <= 4'd0;
      r_sda_oe  <= 1'b0;
      r_rw      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // Pointer advances the cycle after the strobe, so the strobe sees the
      // address the byte belongs to.
      if (r_we) r_addr <= r_addr + 8'd1;

      if (w_start) begin
        r_bit_cnt <= 4'd0;
        r_shift   <= 8'h00;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_bit_cnt <= 4'd0;
        r_shift   <= 8'h00;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (w_scl_rise && r_bit_cnt != cBITS_PER_BYTE) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == cBITS_PER_BYTE - 4'd1) begin
                if (r_state == ST_PTR) r_addr <= w_byte;
                if (r_state == ST_WDATA) begin
                  r_wdata <= w_byte;
                  r_we    <= 1'b1;
                end
              end
            end else if (w_scl_fall && r_bit_cnt == cBITS_PER_BYTE) begin
              r_bit_cnt <= 4'd0;
              if (r_state != ST_ADDR) begin
                r_sda_oe <= 1'b1;
              end else if (w_addr_match) begin
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
                r_rw     <= r_shift[0];
              end else begin
                r_busy <= 1'b0;
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_state == ST_ADDR_ACK && r_rw == cRW_READ) begin
                r_shift  <= iREG_RDATA;
                r_sda_oe <= ~iREG_RDATA[7];
              end else begin
                r_sda_oe <= 1'b0;
              end
            end
          end
          ST_RDATA: begin
            if (w_scl_rise && r_bit_cnt != cBITS_PER_BYTE) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == cBITS_PER_BYTE) begin
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          ST_RDATA_ACK: begin
            // Increment on the sampled ACK so the following fall already
            // sees iREG_RDATA for the next address.
            if (w_scl_rise && w_sda == cACK) begin
              r_addr <= r_addr + 8'd1;
            end else if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              r_shift   <= iREG_RDATA;
              r_sda_oe  <= ~iREG_RDATA[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bSDA       = r_sda_oe ? 1'b0 : 1'bz;
  assign oREG_ADDR  = r_addr;
  assign oREG_WDATA = r_wdata;
  assign oREG_WE    = r_we;
  assign oBUSY      = r_busy;
  assign oSTATE     = r_state;

endmodule

// File: tb/tb_i2c_target.sv
// -----------------------------------------------------------------------------
// tb_i2c_target
// Bench for i2c_target: a timed I2C master driver, a transaction-level model
// of the register pointer and expected write strobes, a per-cycle compare of
// write strobes against that model, and a final report.
// -----------------------------------------------------------------------------
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 10;  // quarter SCL period in iCLK cycles

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl   = 1'b1;
  logic       m_low = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_we;
  logic       busy;
  logic [3:0] state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  m_ptr   = 8'h00;

  pullup (sda_bus);
  assign sda_bus   = m_low ? 1'b0 : 1'bz;
  assign reg_rdata = reg_addr ^ 8'hFF;

  i2c_target #(.pDEV_ADDR(7'h42), .pFILTER(3)) dut (
    .iCLK       (clk),
    .iRESET_N   (rst_n),
    .iSCL       (scl),
    .bSDA       (sda_bus),
    .oREG_ADDR  (reg_addr),
    .oREG_WDATA (reg_wdata),
    .oREG_WE    (reg_we),
    .iREG_RDATA (reg_rdata),
    .oBUSY      (busy),
    .oSTATE     (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic model_we(input logic [7:0] d);
    exp_q.push_back({m_ptr, d});
    m_ptr = m_ptr + 8'd1;
  endtask

  // ---------------- scoreboard: every write strobe against the model ----------------
  always @(negedge clk) begin
    if (rst_n && reg_we) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL we_unexpected: got addr=%h data=%h expected no strobe", reg_addr, reg_wdata);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({reg_addr, reg_wdata} !== e) begin
          n_fail++;
          $display("FAIL we_pair: got %h%h expected %h", reg_addr, reg_wdata, e);
        end
      end
    end
  end

  // ---------------- master driver ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_low = 1'b0; wait_cyc(Q);
    scl   = 1'b1; wait_cyc(Q);
    m_low = 1'b1; wait_cyc(Q);
    scl   = 1'b0; wait_cyc(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; wait_cyc(Q);
    scl   = 1'b1; wait_cyc(Q);
    m_low = 1'b0; wait_cyc(Q);
  endtask

  task automatic put_bit(input logic b);
    m_low = ~b;   wait_cyc(Q);
    scl   = 1'b1; wait_cyc(2 * Q);
    scl   = 1'b0; wait_cyc(Q);
  endtask

  // Data bit with a one-cycle SDA inversion in the middle of the high phase.
  task automatic put_bit_glitch(input logic b);
    m_low = ~b;   wait_cyc(Q);
    scl   = 1'b1; wait_cyc(Q);
    m_low = b;    wait_cyc(1);
    m_low = ~b;   wait_cyc(Q - 1);
    scl   = 1'b0; wait_cyc(Q);
  endtask

  task automatic get_bit(output logic b);
    m_low = 1'b0; wait_cyc(Q);
    scl   = 1'b1; wait_cyc(Q);
    b     = sda_bus; wait_cyc(Q);
    scl   = 1'b0; wait_cyc(Q);
  endtask

  task automatic tx_byte(input string name, input logic [7:0] d, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(a);
    check(name, {15'd0, a}, {15'd0, exp_ack});
  endtask

  // Reads one byte, checks it against the model (pointer ^ 0xFF) and a
  // hand-computed literal, then answers with ACK or NACK.
  task automatic rx_byte(input string name, input logic [7:0] lit, input logic nack);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    check({name, "_model"}, {8'd0, d}, {8'd0, m_ptr ^ 8'hFF});
    check({name, "_lit"}, {8'd0, d}, {8'd0, lit});
    put_bit(nack);
    if (nack == cACK) m_ptr = m_ptr + 8'd1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic b;
    wait_cyc(5);
    check("rst_addr",  {8'd0, reg_addr}, 16'h0000);
    check("rst_wdata", {8'd0, reg_wdata}, 16'h0000);
    check("rst_we",    {15'd0, reg_we}, 16'h0000);
    check("rst_busy",  {15'd0, busy}, 16'h0000);
    check("rst_state", {12'd0, state}, 16'(ST_IDLE));
    check("rst_sda",   {15'd0, sda_bus}, 16'h0001);
    rst_n = 1'b1;
    wait_cyc(10);

    // Write: ptr 0x10, data A5, 5A
    bus_start();
    tx_byte("w1_addr_ack", 8'h84, cACK);
    check("w1_busy", {15'd0, busy}, 16'h0001);
    tx_byte("w1_ptr_ack", 8'h10, cACK);
    m_ptr = 8'h10;
    model_we(8'hA5); tx_byte("w1_d0_ack", 8'hA5, cACK);
    model_we(8'h5A); tx_byte("w1_d1_ack", 8'h5A, cACK);
    bus_stop();
    wait_cyc(Q);
    check("w1_addr_model", {8'd0, reg_addr}, {8'd0, m_ptr});
    check("w1_addr_lit",   {8'd0, reg_addr}, 16'h0012);
    check("w1_idle",       {12'd0, state}, 16'(ST_IDLE));
    check("w1_busy_clr",   {15'd0, busy}, 16'h0000);

    // Read three bytes from 0x12: ACK, ACK, NACK
    bus_start();
    tx_byte("r1_addr_ack", 8'h85, cACK);
    rx_byte("r1_b0", 8'hED, cACK);
    rx_byte("r1_b1", 8'hEC, cACK);
    rx_byte("r1_b2", 8'hEB, cNACK);
    check("r1_wait_stop", {12'd0, state}, 16'(ST_WAIT_STOP));
    bus_stop();
    wait_cyc(Q);
    check("r1_idle",     {12'd0, state}, 16'(ST_IDLE));
    check("r1_addr_lit", {8'd0, reg_addr}, 16'h0014);

    // Wrong address: NACK everywhere, no strobes, never busy
    bus_start();
    tx_byte("na_addr_nack", 8'h86, cNACK);
    check("na_busy0", {15'd0, busy}, 16'h0000);
    tx_byte("na_b0_nack", 8'h11, cNACK);
    tx_byte("na_b1_nack", 8'h22, cNACK);
    check("na_busy1", {15'd0, busy}, 16'h0000);
    bus_stop();
    wait_cyc(Q);
    check("na_addr_kept", {8'd0, reg_addr}, {8'd0, m_ptr});

    // Pointer wrap: 0xFF then 0x00
    bus_start();
    tx_byte("wr_addr_ack", 8'h84, cACK);
    tx_byte("wr_ptr_ack", 8'hFF, cACK);
    m_ptr = 8'hFF;
    model_we(8'h11); tx_byte("wr_d0_ack", 8'h11, cACK);
    model_we(8'h22); tx_byte("wr_d1_ack", 8'h22, cACK);
    bus_stop();
    wait_cyc(Q);
    check("wr_addr_lit", {8'd0, reg_addr}, 16'h0001);

    // Pointer write, repeated START, read from 0x20
    bus_start();
    tx_byte("rs_addr_ack", 8'h84, cACK);
    tx_byte("rs_ptr_ack", 8'h20, cACK);
    m_ptr = 8'h20;
    bus_start();
    tx_byte("rs_raddr_ack", 8'h85, cACK);
    rx_byte("rs_b0", 8'hDF, cNACK);
    bus_stop();
    wait_cyc(Q);
    check("rs_addr_lit", {8'd0, reg_addr}, 16'h0020);

    // STOP after four data bits: partial byte dropped
    bus_start();
    tx_byte("pb_addr_ack", 8'h84, cACK);
    tx_byte("pb_ptr_ack", 8'h30, cACK);
    m_ptr = 8'h30;
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    bus_stop();
    wait_cyc(Q);
    check("pb_idle",     {12'd0, state}, 16'(ST_IDLE));
    check("pb_addr_lit", {8'd0, reg_addr}, 16'h0030);

    // Reset while the target drives a 0 data bit (0x30 -> 0xCF: 1,1,0,...)
    bus_start();
    tx_byte("rr_addr_ack", 8'h85, cACK);
    get_bit(b); check("rr_bit7", {15'd0, b}, 16'h0001);
    get_bit(b); check("rr_bit6", {15'd0, b}, 16'h0001);
    check("rr_driving_low", {15'd0, sda_bus}, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("rr_sda_released", {15'd0, sda_bus}, 16'h0001);
    check("rr_state_idle",   {12'd0, state}, 16'(ST_IDLE));
    wait_cyc(3);
    rst_n = 1'b1;
    m_ptr = 8'h00;
    wait_cyc(2);
    check("rr_addr_cleared", {8'd0, reg_addr}, 16'h0000);
    bus_stop();
    wait_cyc(Q);
    check("rr_idle_after", {12'd0, state}, 16'(ST_IDLE));

    // One-cycle SDA glitch on an idle bus: no START
    m_low = 1'b1; wait_cyc(1);
    m_low = 1'b0; wait_cyc(2 * Q);
    check("gl_idle",  {12'd0, state}, 16'(ST_IDLE));
    check("gl_busy0", {15'd0, busy}, 16'h0000);

    // Glitch during a data bit (SCL high): no false STOP, byte still lands
    bus_start();
    tx_byte("gd_addr_ack", 8'h84, cACK);
    tx_byte("gd_ptr_ack", 8'h40, cACK);
    m_ptr = 8'h40;
    model_we(8'h00);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) put_bit_glitch(1'b0);
      else        put_bit(1'b0);
    end
    get_bit(b);
    check("gd_d0_ack", {15'd0, b}, {15'd0, cACK});
    check("gd_busy", {15'd0, busy}, 16'h0001);
    bus_stop();
    wait_cyc(Q);
    check("gd_addr_lit", {8'd0, reg_addr}, 16'h0041);

    // ---------------- final report ----------------
    check("we_queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
